// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the LEGv8 pipeline hazard logic.
//   fwd_sel_t  - operand forwarding select (regfile / EX ALUOut / MEM data)
//   hz_state_t - hazard controller FSM state
//   ex_rec_t   - bookkeeping for the instruction currently in EX
//   mem_rec_t  - bookkeeping for the instruction currently in MEM
//   XZR        - register number of the zero register (never forwarded)
package cpu_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        STALL1 = 2'b01,
        FLUSH  = 2'b10
    } hz_state_t;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic       setflags;
    } ex_rec_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
    } mem_rec_t;

endpackage

// File: rtl/fwd_match.sv
// fwd_match: compares one RF-stage source operand against the EX and MEM
// records and picks where its value should come from.
//   use_src   in  operand is actually consumed by the RF-stage instruction
//   src       in  operand register number
//   ex_rec    in  EX-stage record
//   mem_rec   in  MEM-stage record
//   sel       out forwarding select (EX wins over MEM)
//   load_use  out operand depends on a load still in EX (value not ready yet)
module fwd_match
    import cpu_pkg::*;
(
    input  logic       use_src,
    input  logic [4:0] src,
    input  ex_rec_t    ex_rec,
    input  mem_rec_t   mem_rec,
    output fwd_sel_t   sel,
    output logic       load_use
);

    logic live_src;
    logic ex_hit;
    logic mem_hit;

    // X31 reads as zero, so a "write" to it must never be forwarded.
    assign live_src = use_src && (src != XZR);
    assign ex_hit   = live_src && ex_rec.valid && ex_rec.regwrite && (ex_rec.rd == src);
    assign mem_hit  = live_src && mem_rec.valid && mem_rec.regwrite && (mem_rec.rd == src);
    assign load_use = ex_hit && ex_rec.memread;

    always_comb begin
        sel = FWD_RF;
        if (load_use) begin
            // The instruction is stalled; the select is irrelevant, keep it quiet.
            sel = FWD_RF;
        end else if (ex_hit) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: RF-stage hazard controller for the five-stage LEGv8 pipeline.
// Tracks the EX and MEM instructions, drives operand and flag forwarding,
// stalls one cycle on load-use and squashes the fetched slot after a taken
// branch.
//   clk, reset             clock, asynchronous active-high reset
//   id_*                   RF-stage instruction fields and control bits
//   forwardOpA/B           00 regfile, 01 EX ALUOut, 10 MEM data
//   forwarding_flags       take N/V from the EX-stage ALU for a B.cond
//   stall / ex_bubble      hold front end, insert NOP into RF/EX
//   flush                  zero the IF/RF register
//   stall_count/flush_count saturating event counters
//   dbg_state              current FSM state, for observation
module hazard_unit
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_setflags,
    input  logic             id_useflags,
    input  logic             id_brtaken,
    output logic [1:0]       forwardOpA,
    output logic [1:0]       forwardOpB,
    output logic             forwarding_flags,
    output logic             stall,
    output logic             ex_bubble,
    output logic             flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output hz_state_t        dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ex_rec_t   ex_rec;
    mem_rec_t  mem_rec;
    hz_state_t state, state_next;
    fwd_sel_t  sel_a, sel_b;
    logic      lu_a, lu_b;

    fwd_match u_match_a (
        .use_src  (id_use_rn),
        .src      (id_rn),
        .ex_rec   (ex_rec),
        .mem_rec  (mem_rec),
        .sel      (sel_a),
        .load_use (lu_a)
    );

    fwd_match u_match_b (
        .use_src  (id_use_rm),
        .src      (id_rm),
        .ex_rec   (ex_rec),
        .mem_rec  (mem_rec),
        .sel      (sel_b),
        .load_use (lu_b)
    );

    assign forwardOpA       = sel_a;
    assign forwardOpB       = sel_b;
    assign forwarding_flags = id_valid && id_useflags && ex_rec.valid && ex_rec.setflags;
    assign dbg_state        = state;

    always_comb begin
        state_next = state;
        // In STALL1 the load has moved to MEM, so any remaining match
        // forwards from MEM instead of stalling again.
        stall      = (lu_a || lu_b) && (state != STALL1);
        ex_bubble  = stall;
        // A stalled branch is re-presented next cycle and flushes then.
        // In FLUSH the RF slot is the squashed one and must not flush again.
        flush      = id_valid && id_brtaken && !stall && (state != FLUSH);
        unique case (state)
            RUN: begin
                if (stall) begin
                    state_next = STALL1;
                end else if (flush) begin
                    state_next = FLUSH;
                end
            end
            STALL1:  state_next = RUN;
            FLUSH:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rec  <= '0;
            mem_rec <= '0;
        end else begin
            mem_rec <= '{valid: ex_rec.valid, rd: ex_rec.rd, regwrite: ex_rec.regwrite};
            ex_rec  <= '{valid:    id_valid && !ex_bubble,
                         rd:       id_rd,
                         regwrite: id_regwrite,
                         memread:  id_memread,
                         setflags: id_setflags};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (flush && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against a
// behavioural model that keeps the in-flight instructions in a queue.
module tb_hazard_unit;
    import cpu_pkg::*;

    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit [4:0] rn;
        bit [4:0] rm;
        bit       use_rn;
        bit       use_rm;
        bit       regwrite;
        bit       memread;
        bit       setflags;
        bit       useflags;
        bit       brtaken;
    } instr_t;

    // ---------------- clock / reset / DUT ----------------
    logic             clk;
    logic             reset;
    logic             id_valid, id_use_rn, id_use_rm;
    logic [4:0]       id_rn, id_rm, id_rd;
    logic             id_regwrite, id_memread, id_setflags, id_useflags, id_brtaken;
    logic [1:0]       forwardOpA, forwardOpB;
    logic             forwarding_flags, stall, ex_bubble, flush;
    logic [CNT_W-1:0] stall_count, flush_count;
    hz_state_t        dbg_state;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_valid         (id_valid),
        .id_rn            (id_rn),
        .id_rm            (id_rm),
        .id_use_rn        (id_use_rn),
        .id_use_rm        (id_use_rm),
        .id_rd            (id_rd),
        .id_regwrite      (id_regwrite),
        .id_memread       (id_memread),
        .id_setflags      (id_setflags),
        .id_useflags      (id_useflags),
        .id_brtaken       (id_brtaken),
        .forwardOpA       (forwardOpA),
        .forwardOpB       (forwardOpB),
        .forwarding_flags (forwarding_flags),
        .stall            (stall),
        .ex_bubble        (ex_bubble),
        .flush            (flush),
        .stall_count      (stall_count),
        .flush_count      (flush_count),
        .dbg_state        (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int     n_checks = 0;
    int     n_pass   = 0;
    int     n_fail   = 0;
    instr_t pipe_q[$];      // [0] = instruction in EX, [1] = in MEM
    bit     prev_stalled;
    bit     flush_block;
    int     exp_scnt, exp_fcnt;

    // observations from the most recent issue()
    int     is_stall, is_flush;
    logic [1:0] pres_fa, pres_fb;
    logic   pres_ff;
    logic   obs_stall, obs_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(bit v, bit [4:0] rd, bit [4:0] rn, bit [4:0] rm,
                                  bit urn, bit urm, bit rw, bit mr, bit sf, bit uf, bit bt);
        instr_t i;
        i.valid = v;  i.rd = rd; i.rn = rn; i.rm = rm;
        i.use_rn = urn; i.use_rm = urm; i.regwrite = rw; i.memread = mr;
        i.setflags = sf; i.useflags = uf; i.brtaken = bt;
        return i;
    endfunction

    function automatic instr_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic model_reset();
        pipe_q.delete();
        pipe_q.push_back(nop());
        pipe_q.push_back(nop());
        prev_stalled = 0;
        flush_block  = 0;
        exp_scnt     = 0;
        exp_fcnt     = 0;
    endtask

    // Youngest in-flight writer of src decides the source; distance 1 = EX,
    // distance 2 = MEM. A load one instruction ahead cannot be forwarded yet.
    function automatic int fwd_of(bit use_src, bit [4:0] src, output bit lu);
        lu = 0;
        if (!use_src || src == 5'd31) return 0;
        for (int k = 0; k < 2; k++) begin
            if (pipe_q[k].valid && pipe_q[k].regwrite && pipe_q[k].rd == src) begin
                if (k == 0 && pipe_q[k].memread) begin
                    lu = 1;
                    return 0;
                end
                return k + 1;
            end
        end
        return 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input instr_t i);
        id_valid    = i.valid;    id_rd       = i.rd;
        id_rn       = i.rn;       id_rm       = i.rm;
        id_use_rn   = i.use_rn;   id_use_rm   = i.use_rm;
        id_regwrite = i.regwrite; id_memread  = i.memread;
        id_setflags = i.setflags; id_useflags = i.useflags;
        id_brtaken  = i.brtaken;
    endtask

    task automatic one_cycle(input instr_t i, output bit st, output bit fl);
        bit lua, lub, ff_e;
        int fa, fb;
        instr_t ent;
        @(negedge clk);
        drive(i);
        #1;
        fa   = fwd_of(i.use_rn, i.rn, lua);
        fb   = fwd_of(i.use_rm, i.rm, lub);
        st   = (lua || lub) && !prev_stalled;
        fl   = i.valid && i.brtaken && !st && !flush_block;
        ff_e = i.valid && i.useflags && pipe_q[0].valid && pipe_q[0].setflags;
        check("forwardOpA", forwardOpA, fa);
        check("forwardOpB", forwardOpB, fb);
        check("forwarding_flags", forwarding_flags, ff_e);
        check("stall", stall, st);
        check("ex_bubble", ex_bubble, st);
        check("flush", flush, fl);
        pres_fa   = forwardOpA;
        pres_fb   = forwardOpB;
        pres_ff   = forwarding_flags;
        obs_stall = stall;
        obs_flush = flush;
        @(posedge clk);
        #1;
        if (st && exp_scnt < CNT_MAX) exp_scnt++;
        if (fl && exp_fcnt < CNT_MAX) exp_fcnt++;
        ent       = i;
        ent.valid = i.valid && !st;
        pipe_q.push_front(ent);
        void'(pipe_q.pop_back());
        flush_block  = fl && !prev_stalled;
        prev_stalled = st;
        check("stall_count", stall_count, exp_scnt);
        check("flush_count", flush_count, exp_fcnt);
    endtask

    // Present one instruction the way the pipeline would: repeat it after a
    // stall, and follow a taken branch with the squashed (empty) slot.
    task automatic issue(input instr_t i);
        bit st, fl;
        logic [1:0] fa_keep, fb_keep;
        logic ff_keep;
        is_stall = 0;
        is_flush = 0;
        one_cycle(i, st, fl);
        is_stall += int'(obs_stall); is_flush += int'(obs_flush);
        if (st) begin
            one_cycle(i, st, fl);
            is_stall += int'(obs_stall); is_flush += int'(obs_flush);
        end
        fa_keep = pres_fa; fb_keep = pres_fb; ff_keep = pres_ff;
        if (fl) begin
            one_cycle(nop(), st, fl);
            is_flush += int'(obs_flush);
        end
        pres_fa = fa_keep; pres_fb = fb_keep; pres_ff = ff_keep;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        drive(nop());
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic bit [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        bit rw;
        if ($urandom_range(0, 9) == 0) return nop();
        rw = ($urandom_range(0, 3) != 0);
        i = mk(1, pick_reg(), pick_reg(), pick_reg(),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               rw, rw && ($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 5) == 0));
        return i;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        reset = 1'b1;
        drive(nop());
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_fwdA", forwardOpA, 0);
        check("rst_fwdB", forwardOpB, 0);
        check("rst_ff", forwarding_flags, 0);
        check("rst_stall", stall, 0);
        check("rst_bubble", ex_bubble, 0);
        check("rst_flush", flush, 0);
        check("rst_scnt", stall_count, 0);
        check("rst_fcnt", flush_count, 0);
        check("rst_state", dbg_state, RUN);
        @(negedge clk);
        reset = 1'b0;

        // idle cycles stay quiet
        repeat (3) issue(nop());
        check("idle_stall", is_stall, 0);

        // ADD X1 -> SUB X2,X1,X3 : EX forward
        issue(mk(1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0));
        issue(mk(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0));
        check("add_sub_fwdA", pres_fa, 2'b01);
        check("add_sub_fwdB", pres_fb, 2'b00);
        // ADD X1 -> independent -> SUB : MEM forward
        issue(mk(1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0));
        issue(mk(1, 9, 10, 11, 1, 1, 1, 0, 0, 0, 0));
        issue(mk(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0));
        check("gap_fwdA", pres_fa, 2'b10);

        // LDUR X4 -> ADD X5,X4,X4 : one stall, then MEM forward
        reset_dut();
        issue(mk(1, 4, 6, 0, 1, 0, 1, 1, 0, 0, 0));
        issue(mk(1, 5, 4, 4, 1, 1, 1, 0, 0, 0, 0));
        check("lu_stalls", is_stall, 1);
        check("lu_fwdA", pres_fa, 2'b10);
        check("lu_fwdB", pres_fb, 2'b10);
        check("lu_scnt", stall_count, 1);

        // flag forwarding
        issue(mk(1, 1, 2, 3, 1, 1, 1, 0, 1, 0, 0));
        issue(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        check("adds_blt_ff", pres_ff, 1'b1);
        issue(mk(1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0));
        issue(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        check("add_blt_ff", pres_ff, 1'b0);

        // taken branches
        reset_dut();
        issue(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        check("b_flushes", is_flush, 1);
        check("b_fcnt", flush_count, 1);
        issue(mk(1, 2, 6, 0, 1, 0, 1, 1, 0, 0, 0));
        issue(mk(1, 0, 0, 2, 0, 1, 0, 0, 0, 0, 1));
        check("cbz_stalls", is_stall, 1);
        check("cbz_flushes", is_flush, 1);
        check("cbz_fcnt", flush_count, 2);
        check("cbz_scnt", stall_count, 1);

        // X31 is never forwarded and never stalls
        issue(mk(1, 31, 2, 3, 1, 1, 1, 0, 0, 0, 0));
        issue(mk(1, 1, 31, 31, 1, 1, 1, 0, 0, 0, 0));
        check("xzr_fwdA", pres_fa, 2'b00);
        check("xzr_fwdB", pres_fb, 2'b00);
        issue(mk(1, 31, 6, 0, 1, 0, 1, 1, 0, 0, 0));
        issue(mk(1, 1, 31, 31, 1, 1, 1, 0, 0, 0, 0));
        check("xzr_ld_stalls", is_stall, 0);

        // asynchronous reset in the middle of a stall
        issue(mk(1, 4, 6, 0, 1, 0, 1, 1, 0, 0, 0));
        @(negedge clk);
        drive(mk(1, 5, 4, 4, 1, 1, 1, 0, 0, 0, 0));
        #1;
        check("mid_stall_pre", stall, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_stall", stall, 0);
        check("mid_rst_bubble", ex_bubble, 0);
        check("mid_rst_state", dbg_state, RUN);
        check("mid_rst_scnt", stall_count, 0);
        @(negedge clk);
        drive(nop());
        reset = 1'b0;
        model_reset();

        // counter saturation
        for (int n = 0; n < CNT_MAX + 6; n++) begin
            issue(mk(1, 4, 6, 0, 1, 0, 1, 1, 0, 0, 0));
            issue(mk(1, 5, 4, 4, 1, 1, 1, 0, 0, 0, 0));
        end
        check("sat_scnt", stall_count, CNT_MAX);

        // randomized traffic
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            issue(rand_instr());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
